// File: rtl/exu_muldiv.sv
// Multi-cycle RV32M execute unit: iterative shift-add multiplier and restoring divider
// sharing one 2*XLEN accumulator, with valid/ready handshakes and a pipeline flush.
module exu_muldiv #(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1,
  parameter int TAG_WIDTH      = 5
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [2:0]           i_funct3,
  input  logic [XLEN-1:0]      i_rs1_rd_data,
  input  logic [XLEN-1:0]      i_rs2_rd_data,
  input  logic [TAG_WIDTH-1:0] i_tag,
  input  logic                 i_flush,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [XLEN-1:0]      o_dout,
  output logic [TAG_WIDTH-1:0] o_tag,
  output logic                 o_busy
);

  localparam int CNT_W = $clog2(XLEN / BITS_PER_CYCLE + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(XLEN / BITS_PER_CYCLE);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q;
  logic [2:0]             op_q;
  logic [TAG_WIDTH-1:0]   tag_q;
  logic                   neg_q;
  logic [XLEN-1:0]        opnd_q;
  logic [2*XLEN-1:0]      acc_q, acc_n;

  logic                   accept, signed_a, signed_b, sgn_a, sgn_b;
  logic                   div_zero, div_ovf, special;
  logic [XLEN-1:0]        a_mag, b_mag, special_res;
  logic [XLEN:0]          sum, rem_ext, diff;
  logic [2*XLEN-1:0]      prod_fix;
  logic [XLEN-1:0]        div_raw, div_fix, calc_res;

  assign o_ready = (state_q == IDLE);
  assign o_valid = (state_q == DONE);
  assign o_busy  = (state_q != IDLE);
  assign accept  = i_valid && o_ready && !i_flush;

  // Operand conditioning at accept: magnitudes, result sign, and the
  // divide-by-zero / signed-overflow shortcuts that skip iteration.
  always_comb begin
    signed_a    = (i_funct3 == 3'b001) || (i_funct3 == 3'b010) ||
                  (i_funct3 == 3'b100) || (i_funct3 == 3'b110);
    signed_b    = (i_funct3 == 3'b001) || (i_funct3 == 3'b100) || (i_funct3 == 3'b110);
    sgn_a       = signed_a && i_rs1_rd_data[XLEN-1];
    sgn_b       = signed_b && i_rs2_rd_data[XLEN-1];
    a_mag       = sgn_a ? -i_rs1_rd_data : i_rs1_rd_data;
    b_mag       = sgn_b ? -i_rs2_rd_data : i_rs2_rd_data;
    div_zero    = i_funct3[2] && (i_rs2_rd_data == '0);
    div_ovf     = i_funct3[2] && !i_funct3[0] &&
                  (i_rs1_rd_data == {1'b1, {(XLEN-1){1'b0}}}) && (i_rs2_rd_data == '1);
    special     = div_zero || div_ovf;
    special_res = '0;
    if (div_zero)
      special_res = i_funct3[1] ? i_rs1_rd_data : '1;
    else if (div_ovf)
      special_res = i_funct3[1] ? '0 : i_rs1_rd_data;
  end

  // One CALC cycle: BITS_PER_CYCLE multiply or divide steps on the accumulator.
  // Multiply keeps {hi, multiplier}; divide keeps {remainder, dividend/quotient}.
  always_comb begin
    acc_n   = acc_q;
    sum     = '0;
    rem_ext = '0;
    diff    = '0;
    for (int k = 0; k < BITS_PER_CYCLE; k++) begin
      if (op_q[2]) begin
        rem_ext = acc_n[2*XLEN-1:XLEN-1];
        diff    = rem_ext - {1'b0, opnd_q};
        if (!diff[XLEN])
          acc_n = {diff[XLEN-1:0], acc_n[XLEN-2:0], 1'b1};
        else
          acc_n = {rem_ext[XLEN-1:0], acc_n[XLEN-2:0], 1'b0};
      end else begin
        sum   = {1'b0, acc_n[2*XLEN-1:XLEN]} + (acc_n[0] ? {1'b0, opnd_q} : '0);
        acc_n = {sum, acc_n[XLEN-1:1]};
      end
    end
  end

  always_comb begin
    prod_fix = neg_q ? -acc_n : acc_n;
    div_raw  = op_q[1] ? acc_n[2*XLEN-1:XLEN] : acc_n[XLEN-1:0];
    div_fix  = neg_q ? -div_raw : div_raw;
    case (op_q)
      3'b000:  calc_res = prod_fix[XLEN-1:0];
      3'b001,
      3'b010,
      3'b011:  calc_res = prod_fix[2*XLEN-1:XLEN];
      default: calc_res = div_fix;
    endcase
  end

  // Next-state logic; flush overrides everything, including accept and take.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = special ? DONE : CALC;
      CALC:    if (cnt_q == CNT_LAST) state_d = DONE;
      DONE:    if (i_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (i_flush) state_d = IDLE;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      tag_q   <= '0;
      neg_q   <= 1'b0;
      opnd_q  <= '0;
      acc_q   <= '0;
      o_dout  <= '0;
      o_tag   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q   <= i_funct3;
        tag_q  <= i_tag;
        neg_q  <= (i_funct3[2] && i_funct3[1]) ? sgn_a : (sgn_a ^ sgn_b);
        opnd_q <= i_funct3[2] ? b_mag : a_mag;
        acc_q  <= {{XLEN{1'b0}}, (i_funct3[2] ? a_mag : b_mag)};
        cnt_q  <= CNT_INIT;
        if (special) begin
          o_dout <= special_res;
          o_tag  <= i_tag;
        end
      end else if (state_q == CALC && !i_flush) begin
        acc_q <= acc_n;
        cnt_q <= cnt_q - CNT_LAST;
        if (cnt_q == CNT_LAST) begin
          o_dout <= calc_res;
          o_tag  <= tag_q;
        end
      end
    end
  end

endmodule

// File: tb/tb_exu_muldiv.sv
// Scoreboarded directed bench for exu_muldiv: one instance with 1 bit/cycle and one
// with 4 bits/cycle, checking results, tags, latency, back-pressure, flush and reset.
module tb_exu_muldiv;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  funct3;
  logic [31:0] rs1, rs2;
  logic [4:0]  tag;
  logic        flush;
  logic [1:0]  vin, rin, rdy, vout, busy;
  logic [31:0] dout0, dout1;
  logic [4:0]  otag0, otag1;

  int ncmp  = 0;
  int nfail = 0;

  typedef struct {
    logic [31:0] d;
    logic [4:0]  t;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  exu_muldiv #(.XLEN(32), .BITS_PER_CYCLE(1), .TAG_WIDTH(5)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(vin[0]), .o_ready(rdy[0]),
    .i_funct3(funct3), .i_rs1_rd_data(rs1), .i_rs2_rd_data(rs2), .i_tag(tag),
    .i_flush(flush), .o_valid(vout[0]), .i_ready(rin[0]), .o_dout(dout0),
    .o_tag(otag0), .o_busy(busy[0])
  );

  exu_muldiv #(.XLEN(32), .BITS_PER_CYCLE(4), .TAG_WIDTH(5)) u_dut4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(vin[1]), .o_ready(rdy[1]),
    .i_funct3(funct3), .i_rs1_rd_data(rs1), .i_rs2_rd_data(rs2), .i_tag(tag),
    .i_flush(flush), .o_valid(vout[1]), .i_ready(rin[1]), .o_dout(dout1),
    .o_tag(otag1), .o_busy(busy[1])
  );

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("[TB] FAIL %s: observed=%h expected=%h", name, obs, exp);
    end
  endtask

  function automatic logic [31:0] doutOf(input int w);
    return (w == 0) ? dout0 : dout1;
  endfunction

  function automatic logic [31:0] tagOf(input int w);
    return {27'b0, (w == 0) ? otag0 : otag1};
  endfunction

  // Drive one request; the expected result goes on the scoreboard only if it should emerge.
  task automatic applyStimulus(input int w, input logic [2:0] f, input logic [31:0] a,
                               input logic [31:0] b, input logic [4:0] t,
                               input bit keep, input logic [31:0] exp);
    exp_t e;
    funct3 = f; rs1 = a; rs2 = b; tag = t; vin[w] = 1'b1;
    check("ready_at_accept", {31'b0, rdy[w]}, 32'd1);
    @(posedge clk); #1;
    vin[w] = 1'b0;
    funct3 = 3'($urandom); rs1 = $urandom; rs2 = $urandom; tag = 5'($urandom);
    if (keep) begin
      e.d = exp; e.t = t;
      sb.push_back(e);
    end
  endtask

  // Wait for o_valid (bounded), compare against the scoreboard, optionally stall, then take.
  task automatic checkOutput(input int w, input int lat, input string name, input int hold);
    exp_t e;
    int waited = 0;
    logic [31:0] d0, t0;
    while (!vout[w] && waited < 100) begin
      @(posedge clk); #1;
      waited++;
    end
    check({name, "_latency"}, waited, lat - 1);
    if (vout[w]) begin
      if (sb.size() == 0) begin
        check({name, "_scoreboard_empty"}, 32'd0, 32'd1);
      end else begin
        e = sb.pop_front();
        check({name, "_dout"}, doutOf(w), e.d);
        check({name, "_tag"}, tagOf(w), {27'b0, e.t});
      end
      d0 = doutOf(w); t0 = tagOf(w);
      repeat (hold) begin
        @(posedge clk); #1;
        check({name, "_stall_dout"}, doutOf(w), d0);
        check({name, "_stall_tag"}, tagOf(w), t0);
        check({name, "_stall_ready"}, {31'b0, rdy[w]}, 32'd0);
        check({name, "_stall_valid"}, {31'b0, vout[w]}, 32'd1);
      end
      rin[w] = 1'b1;
      @(posedge clk); #1;
      rin[w] = 1'b0;
      check({name, "_ready_after_take"}, {31'b0, rdy[w]}, 32'd1);
      check({name, "_valid_after_take"}, {31'b0, vout[w]}, 32'd0);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int seen;
    rst_n = 1'b0; vin = '0; rin = '0; flush = 1'b0;
    funct3 = '0; rs1 = '0; rs2 = '0; tag = '0;
    #12;
    check("rst_valid", {31'b0, vout[0]}, 32'd0);
    check("rst_ready", {31'b0, rdy[0]},  32'd1);
    check("rst_busy",  {31'b0, busy[0]}, 32'd0);
    check("rst_dout",  dout0, 32'd0);
    check("rst_tag",   {27'b0, otag0}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    applyStimulus(0, 3'b000, 32'd7, 32'hFFFF_FFFD, 5'd1, 1, 32'hFFFF_FFEB);
    checkOutput(0, 33, "mul", 0);
    applyStimulus(0, 3'b001, 32'h8000_0000, 32'h8000_0000, 5'd2, 1, 32'h4000_0000);
    checkOutput(0, 33, "mulh", 0);
    applyStimulus(0, 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 1, 32'hFFFF_FFFF);
    checkOutput(0, 33, "mulhsu", 0);
    applyStimulus(0, 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 1, 32'hFFFF_FFFE);
    checkOutput(0, 33, "mulhu", 0);
    applyStimulus(0, 3'b100, 32'hFFFF_FFF9, 32'd2, 5'd5, 1, 32'hFFFF_FFFD);
    checkOutput(0, 33, "div", 0);
    applyStimulus(0, 3'b110, 32'hFFFF_FFF9, 32'd2, 5'd6, 1, 32'hFFFF_FFFF);
    checkOutput(0, 33, "rem", 0);
    applyStimulus(0, 3'b101, 32'hFFFF_FFFF, 32'h10, 5'd7, 1, 32'h0FFF_FFFF);
    checkOutput(0, 33, "divu", 0);
    applyStimulus(0, 3'b100, 32'd5, 32'd0, 5'd8, 1, 32'hFFFF_FFFF);
    checkOutput(0, 1, "div_by_zero", 0);
    applyStimulus(0, 3'b111, 32'd5, 32'd0, 5'd9, 1, 32'd5);
    checkOutput(0, 1, "remu_by_zero", 0);
    applyStimulus(0, 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 1, 32'h8000_0000);
    checkOutput(0, 1, "div_overflow", 0);
    applyStimulus(0, 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 1, 32'd0);
    checkOutput(0, 1, "rem_overflow", 0);
    applyStimulus(0, 3'b011, 32'h1234_5678, 32'h9ABC_DEF0, 5'd12, 1, 32'h0B00_EA4E);
    checkOutput(0, 33, "backpressure", 10);

    // Flush in the accept cycle must drop the request.
    funct3 = 3'b000; rs1 = 32'd2; rs2 = 32'd2; vin[0] = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    vin[0] = 1'b0; flush = 1'b0;
    check("flush_vs_accept_busy", {31'b0, busy[0]}, 32'd0);

    // Flush at T+10 of a divide: no result may ever appear.
    applyStimulus(0, 3'b100, 32'd100, 32'd7, 5'd14, 0, 32'd0);
    repeat (9) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_ready", {31'b0, rdy[0]}, 32'd1);
    check("flush_valid", {31'b0, vout[0]}, 32'd0);
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (vout[0]) seen++;
    end
    check("flush_no_result", seen, 32'd0);

    applyStimulus(0, 3'b000, 32'd3, 32'd4, 5'd13, 1, 32'd12);
    checkOutput(0, 33, "mul_after_flush", 0);

    // Asynchronous reset in the middle of CALC.
    applyStimulus(0, 3'b000, 32'd5, 32'd6, 5'd15, 0, 32'd0);
    repeat (5) begin @(posedge clk); #1; end
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_valid", {31'b0, vout[0]}, 32'd0);
    check("midrst_ready", {31'b0, rdy[0]},  32'd1);
    check("midrst_busy",  {31'b0, busy[0]}, 32'd0);
    check("midrst_dout",  dout0, 32'd0);
    check("midrst_tag",   {27'b0, otag0}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    applyStimulus(1, 3'b000, 32'd7, 32'hFFFF_FFFD, 5'd17, 1, 32'hFFFF_FFEB);
    checkOutput(1, 9, "b4_mul", 0);
    applyStimulus(1, 3'b001, 32'h8000_0000, 32'h8000_0000, 5'd18, 1, 32'h4000_0000);
    checkOutput(1, 9, "b4_mulh", 0);
    applyStimulus(1, 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd19, 1, 32'hFFFF_FFFE);
    checkOutput(1, 9, "b4_mulhu", 0);
    applyStimulus(1, 3'b100, 32'hFFFF_FFF9, 32'd2, 5'd20, 1, 32'hFFFF_FFFD);
    checkOutput(1, 9, "b4_div", 0);
    applyStimulus(1, 3'b110, 32'hFFFF_FFF9, 32'd2, 5'd21, 1, 32'hFFFF_FFFF);
    checkOutput(1, 9, "b4_rem", 0);
    applyStimulus(1, 3'b101, 32'hFFFF_FFFF, 32'h10, 5'd22, 1, 32'h0FFF_FFFF);
    checkOutput(1, 9, "b4_divu", 0);
    applyStimulus(1, 3'b100, 32'd5, 32'd0, 5'd23, 1, 32'hFFFF_FFFF);
    checkOutput(1, 1, "b4_div_by_zero", 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/exu_muldiv.md
Name: exu_muldiv

Overview:
- Multi-cycle RV32M execute unit: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
- Sits beside the single-cycle execute ALU in EX and uses the same operand/result data width.
- Iterative shift-add multiplier and restoring divider, retiring BITS_PER_CYCLE bits per cycle.
- Valid/ready handshake on input and output, plus a pipeline flush input.

Parameters:
- XLEN, 32: operand and result width.
- BITS_PER_CYCLE, 1: quotient/multiplier bits processed per CALC cycle. Legal values 1, 2, 4; XLEN must be divisible by it.
- TAG_WIDTH, 5: width of the destination-register tag carried through.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_valid  in  1  request valid
- o_ready  out  1  unit can accept a request
- i_funct3  in  3  RV32M funct3 (000 MUL … 111 REMU)
- i_rs1_rd_data  in  XLEN  operand A
- i_rs2_rd_data  in  XLEN  operand B
- i_tag  in  TAG_WIDTH  rd address, passed through
- i_flush  in  1  kill the in-flight or pending operation
- o_valid  out  1  result valid
- i_ready  in  1  consumer accepts result
- o_dout  out  XLEN  result
- o_tag  out  TAG_WIDTH  tag of the result
- o_busy  out  1  state != IDLE

Behaviour:
- Reset (i_rst_n=0, asynchronous):
  - state=IDLE.
  - o_valid=0, o_dout=0, o_tag=0, o_busy=0, o_ready=1.
  - All internal accumulators cleared.
- States IDLE, CALC, DONE. o_ready=1 only in IDLE.
- Accept: i_valid&&o_ready&&!i_flush in cycle T latches funct3, operands and tag.
  - Normal ops go to CALC with counter=XLEN/BITS_PER_CYCLE.
  - Special-case ops go directly to DONE, so o_valid=1 at T+1.
- Special cases, resolved without iteration:
  - Divide by zero: DIV/DIVU -> all ones; REM/REMU -> operand A.
  - Signed overflow (DIV/REM, A=most-negative, B=-1): DIV -> A; REM -> 0.
- Sign handling at accept:
  - Signed operands are converted to magnitude. Signed: MULH (A,B), MULHSU (A only), DIV/REM (A,B).
  - Negate flags: product sign = signA^signB. Quotient sign = signA^signB. Remainder sign = signA.
- CALC: each cycle processes BITS_PER_CYCLE bits and decrements the counter.
  - Multiply: 2*XLEN product register, shift-add, LSB-first on operand B.
  - Divide: restoring, MSB-first, XLEN-bit remainder.
  - When the counter reaches 1 the state moves to DONE. The sign fix-up (2*XLEN negation for products) is applied on that transition.
  - Normal-op latency: o_valid rises at cycle T + XLEN/BITS_PER_CYCLE + 1 (T+33 for defaults).
- Result selection:
  - MUL: product[XLEN-1:0].
  - MULH/MULHSU/MULHU: product[2*XLEN-1:XLEN].
  - DIV/DIVU: quotient.
  - REM/REMU: remainder.
- DONE: o_valid=1; o_dout and o_tag are stable until the result is taken.
  - The result is taken on the cycle with o_valid&&i_ready; the next state is IDLE.
  - No same-cycle re-accept: o_ready stays 0 in DONE.
- Flush:
  - i_flush=1 in any state -> IDLE next cycle, o_valid=0 next cycle, no result emitted.
  - Flush wins over a same-cycle accept and over a same-cycle result take. The consumer must ignore the result in a flush cycle.
- o_dout/o_tag keep their last value in IDLE. Only o_valid qualifies them.
- i_funct3 and operand inputs are ignored outside the accept cycle.

Test Plan:
- MUL 7*(-3), then MULH 0x80000000*0x80000000 -> 0xFFFFFFEB at T+33; 0x40000000 at T+33.
- MULHSU A=0xFFFFFFFF (-1), B=0xFFFFFFFF (unsigned) -> 0xFFFFFFFF. MULHU same operands -> 0xFFFFFFFE.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 0xFFFFFFFF/0x10 -> 0x0FFFFFFF. Each arrives at T+33.
- Special cases:
  - DIV 5/0 -> 0xFFFFFFFF at T+1.
  - REMU 5/0 -> 5 at T+1.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000 at T+1; REM of the same operands -> 0 at T+1.
- Back-pressure: hold i_ready=0 for 10 cycles after o_valid -> o_dout/o_tag stable, o_ready=0. Release -> IDLE next cycle, o_ready=1.
- Flush and reset:
  - Flush at T+10 of a DIV -> o_valid never asserts, o_ready=1 at T+11.
  - A new MUL 3*4 accepted afterwards -> 12.
  - Assert i_rst_n=0 mid-CALC -> all outputs at reset values immediately.
  - Rerun with BITS_PER_CYCLE=4 -> the same results arrive at T+9.
